value_prediction_checker: RTL and testbench



---
 rtl/vp_pkg.sv | 17 +
 rtl/vp_fifo.sv | 57 +++++
 rtl/value_prediction_checker.sv | 143 ++++++++++++++
 tb/tb_value_prediction_checker.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/vp_pkg.sv
// Shared types for the load value prediction checker.
// Optional VPC_STATS_EN adds prediction statistics counters.
package vp_pkg;

   typedef enum logic [0:0] {
      CHECK   = 1'b0,
      RECOVER = 1'b1
   } vp_state_t;

   localparam int VPC_STATS_W = 16;

   // Bit width of one outstanding-load record: {pc, predicted, pred_data}.
   function automatic int vp_entry_width(int aw, int dw);
      return aw + 1 + dw;
   endfunction

endpackage

// File: rtl/vp_fifo.sv
// In-order FIFO with synchronous clear and same-cycle push/pop.
// Clear wins over a concurrent push.
module vp_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_cnt;

   logic w_do_pop;
   logic w_do_push;

   assign full_o    = (r_cnt == (AW+1)'(DEPTH));
   assign empty_o   = (r_cnt == '0);
   assign dout_o    = r_mem[r_rd];
   assign w_do_pop  = pop_i && !empty_o;
   // A pop frees the head slot on this edge, so a full FIFO may still accept.
   assign w_do_push = push_i && (!full_o || w_do_pop);

   always_ff @(posedge clk_i) begin
      if (w_do_push && !clr_i) begin
         r_mem[r_wr] <= din_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + 1'b1;
         if (w_do_pop)  r_rd <= r_rd + 1'b1;
         unique case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/value_prediction_checker.sv
// Checks in-order load responses against recorded value predictions.
// Define VPC_STATS_EN for predicted/mispredict statistics counters.
module value_prediction_checker
   import vp_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDRESS_WIDTH  = 32,
   parameter int QUEUE_DEPTH    = 4,
   parameter int RECOVER_CYCLES = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     ex_is_load_i,
   input  logic [ADDRESS_WIDTH-1:0] ex_pc_i,
   input  logic                     ex_predicted_i,
   input  logic [DATA_WIDTH-1:0]    ex_predicted_data_i,
   input  logic                     dmem_is_valid_i,
   input  logic                     dmem_read_write_n_i,
   input  logic [DATA_WIDTH-1:0]    dmem_data_i,
   output logic                     stall_o,
   output logic                     flush_o,
   output logic                     mispredict_o,
   output logic                     old_value_predicted_o,
   output logic [ADDRESS_WIDTH-1:0] revert_pc_o,
`ifdef VPC_STATS_EN
   output logic [VPC_STATS_W-1:0]   predicted_count_o,
   output logic [VPC_STATS_W-1:0]   mispredict_count_o,
`endif
   output logic [DATA_WIDTH-1:0]    corrected_data_o
);

   typedef struct packed {
      logic [ADDRESS_WIDTH-1:0] pc;
      logic                     predicted;
      logic [DATA_WIDTH-1:0]    pred_data;
   } entry_t;

   localparam int EW = vp_entry_width(ADDRESS_WIDTH, DATA_WIDTH);
   localparam int CW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

   vp_state_t                r_state;
   logic [CW-1:0]            r_cnt;
   logic                     r_mis;
   logic                     r_oldp;
   logic [ADDRESS_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0]    r_cd;

   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic          w_push;
   logic          w_mis;
   entry_t        w_in;
   entry_t        w_head;
   logic [EW-1:0] w_head_bits;

   assign w_pop   = dmem_is_valid_i && dmem_read_write_n_i
                    && !w_empty && (r_state == CHECK);
   assign stall_o = (w_full && !w_pop) || (r_state == RECOVER);
   assign w_push  = ex_is_load_i && !stall_o;
   assign w_head  = entry_t'(w_head_bits);
   assign w_mis   = w_pop && w_head.predicted
                    && (dmem_data_i != w_head.pred_data);

   always_comb begin
      w_in           = '0;
      w_in.pc        = ex_pc_i;
      w_in.predicted = ex_predicted_i;
      w_in.pred_data = ex_predicted_data_i;
   end

   // Clearing on a mispredict squashes every younger load, incl. this cycle's.
   vp_fifo #(
      .W     (EW),
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (w_mis),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .din_i   (EW'(w_in)),
      .dout_o  (w_head_bits),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= CHECK;
         r_cnt   <= '0;
         r_mis   <= 1'b0;
         r_oldp  <= 1'b0;
         r_pc    <= '0;
         r_cd    <= '0;
      end else begin
         r_mis  <= w_mis;
         r_oldp <= w_pop && w_head.predicted;
         if (w_pop) begin
            r_pc <= w_head.pc;
            r_cd <= dmem_data_i;
         end
         unique case (r_state)
            CHECK: begin
               if (w_mis) begin
                  r_state <= RECOVER;
                  r_cnt   <= CW'(RECOVER_CYCLES - 1);
               end
            end
            RECOVER: begin
               if (r_cnt == '0) r_state <= CHECK;
               else             r_cnt   <= r_cnt - 1'b1;
            end
            default: r_state <= CHECK;
         endcase
      end
   end

   assign flush_o               = (r_state == RECOVER);
   assign mispredict_o          = r_mis;
   assign old_value_predicted_o = r_oldp;
   assign revert_pc_o           = r_pc;
   assign corrected_data_o      = r_cd;

`ifdef VPC_STATS_EN
   logic [VPC_STATS_W-1:0] r_pred_cnt;
   logic [VPC_STATS_W-1:0] r_mis_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pred_cnt <= '0;
         r_mis_cnt  <= '0;
      end else begin
         if (r_oldp && (r_pred_cnt != '1)) r_pred_cnt <= r_pred_cnt + 1'b1;
         if (r_mis && (r_mis_cnt != '1))   r_mis_cnt  <= r_mis_cnt + 1'b1;
      end
   end

   assign predicted_count_o  = r_pred_cnt;
   assign mispredict_count_o = r_mis_cnt;
`endif

endmodule

// File: tb/tb_value_prediction_checker.sv
// Directed plus random test of value_prediction_checker against a queue model.
// Stats ports are exercised only when VPC_STATS_EN is defined.
module tb_value_prediction_checker;

   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 4;
   localparam int RC    = 2;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          ex_is_load_i;
   logic [AW-1:0] ex_pc_i;
   logic          ex_predicted_i;
   logic [DW-1:0] ex_predicted_data_i;
   logic          dmem_is_valid_i;
   logic          dmem_read_write_n_i;
   logic [DW-1:0] dmem_data_i;
   logic          stall_o;
   logic          flush_o;
   logic          mispredict_o;
   logic          old_value_predicted_o;
   logic [AW-1:0] revert_pc_o;
   logic [DW-1:0] corrected_data_o;
`ifdef VPC_STATS_EN
   logic [15:0]   predicted_count_o;
   logic [15:0]   mispredict_count_o;
`endif

   always #5 clk_i = ~clk_i;

   value_prediction_checker #(
      .DATA_WIDTH     (DW),
      .ADDRESS_WIDTH  (AW),
      .QUEUE_DEPTH    (DEPTH),
      .RECOVER_CYCLES (RC)
   ) dut (
      .clk_i                 (clk_i),
      .rst_i                 (rst_i),
      .ex_is_load_i          (ex_is_load_i),
      .ex_pc_i               (ex_pc_i),
      .ex_predicted_i        (ex_predicted_i),
      .ex_predicted_data_i   (ex_predicted_data_i),
      .dmem_is_valid_i       (dmem_is_valid_i),
      .dmem_read_write_n_i   (dmem_read_write_n_i),
      .dmem_data_i           (dmem_data_i),
      .stall_o               (stall_o),
      .flush_o               (flush_o),
      .mispredict_o          (mispredict_o),
      .old_value_predicted_o (old_value_predicted_o),
      .revert_pc_o           (revert_pc_o),
`ifdef VPC_STATS_EN
      .predicted_count_o     (predicted_count_o),
      .mispredict_count_o    (mispredict_count_o),
`endif
      .corrected_data_o      (corrected_data_o)
   );

   typedef struct {
      logic [AW-1:0] pc;
      bit            pred;
      logic [DW-1:0] pd;
   } ent_t;

   ent_t          q[$];
   int            flush_left = 0;
   bit            e_mis = 0;
   bit            e_oldp = 0;
   logic [AW-1:0] e_pc = '0;
   logic [DW-1:0] e_cd = '0;
   int            passed = 0;
   int            total = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step(input bit rst, input bit ld, input logic [AW-1:0] pc,
                       input bit pr, input logic [DW-1:0] pdat,
                       input bit dv, input bit rw, input logic [DW-1:0] dd);
      bit   pop;
      bit   push;
      bit   exp_stall;
      ent_t h;
      ent_t n;
      @(negedge clk_i);
      rst_i               = rst;
      ex_is_load_i        = ld;
      ex_pc_i             = pc;
      ex_predicted_i      = pr;
      ex_predicted_data_i = pdat;
      dmem_is_valid_i     = dv;
      dmem_read_write_n_i = rw;
      dmem_data_i         = dd;
      #1;
      pop       = dv && rw && (q.size() != 0) && (flush_left == 0);
      exp_stall = ((q.size() == DEPTH) && !pop) || (flush_left > 0);
      push      = ld && !exp_stall;
      chk("stall", stall_o, exp_stall);
      if (rst) begin
         q.delete();
         flush_left = 0;
         e_mis = 0; e_oldp = 0; e_pc = '0; e_cd = '0;
      end else begin
         e_mis  = 0;
         e_oldp = 0;
         if (flush_left > 0) begin
            flush_left--;
         end else if (pop) begin
            h      = q.pop_front();
            e_oldp = h.pred;
            e_pc   = h.pc;
            e_cd   = dd;
            e_mis  = h.pred && (dd != h.pd);
            if (e_mis) begin
               q.delete();
               flush_left = RC;
            end
         end
         if (push && !e_mis) begin
            n.pc = pc; n.pred = pr; n.pd = pdat;
            q.push_back(n);
         end
      end
      @(posedge clk_i);
      #1;
      chk("mispredict", mispredict_o, e_mis);
      chk("old_pred", old_value_predicted_o, e_oldp);
      chk("revert_pc", revert_pc_o, e_pc);
      chk("corrected", corrected_data_o, e_cd);
      chk("flush", flush_o, flush_left > 0);
   endtask

   task automatic idle();
      step(0, 0, '0, 0, '0, 0, 0, '0);
   endtask

   task automatic load(input logic [AW-1:0] pc, input bit pr,
                       input logic [DW-1:0] pd);
      step(0, 1, pc, pr, pd, 0, 0, '0);
   endtask

   task automatic rsp(input logic [DW-1:0] d);
      step(0, 0, '0, 0, '0, 1, 1, d);
   endtask

   initial begin
      logic [AW-1:0] pcs [4];
      step(1, 0, '0, 0, '0, 0, 0, '0);
      step(1, 0, '0, 0, '0, 0, 0, '0);
      idle();
      // correct prediction
      load(32'h40, 1, 32'hAB);
      rsp(32'hAB);
      idle();
      // misprediction, response during recovery, empty read after
      load(32'h44, 1, 32'h10);
      load(32'h48, 0, 32'h0);
      rsp(32'h11);
      rsp(32'h22);
      idle();
      rsp(32'h33);
      idle();
      // unpredicted load
      load(32'h50, 0, 32'h0);
      rsp(32'h5);
      // full queue
      for (int i = 0; i < 4; i++) begin
         pcs[i] = $urandom & 32'hFFFC;
         load(pcs[i], 1, 32'h100 + i);
      end
      load(32'h99, 1, 32'h1);
      step(0, 1, 32'h60, 1, 32'h200, 1, 1, 32'h100);
      rsp(32'h101);
      rsp(32'h102);
      rsp(32'h103);
      rsp(32'h200);
      // empty read and write response
      rsp(32'h7);
      step(0, 0, '0, 0, '0, 1, 0, 32'h9);
      load(32'h70, 1, 32'h1);
      step(0, 0, '0, 0, '0, 1, 0, 32'h2);
      rsp(32'h1);
      // random traffic
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom,
              $urandom_range(0, 1), $urandom_range(0, 3),
              $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
              $urandom_range(0, 3));
      end
      // reset on first flush cycle
      step(1, 0, '0, 0, '0, 0, 0, '0);
      load(32'h80, 1, 32'h1);
      load(32'h84, 1, 32'h2);
      rsp(32'h5);
      step(1, 0, '0, 0, '0, 0, 0, '0);
      idle();
      rsp(32'h2);
`ifdef VPC_STATS_EN
      chk("pred_count", predicted_count_o, 16'h0);
      chk("mis_count", mispredict_count_o, 16'h0);
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
